// File: rtl/led_breath_multi.sv
// led_breath_multi: multi-channel LED breathing engine (all-channel or chase mode) with PWM drive.
// Build option: define LED_BREATH_GAMMA_EN to square the brightness before the PWM compare.
module led_breath_multi #(
  parameter int N_LED       = 8,
  parameter int PWM_BITS    = 4,
  parameter int STEP_CYCLES = 4,
  parameter int HOLD_STEPS  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic [N_LED-1:0]    led_mask,
  input  logic                pause,
  output logic [N_LED-1:0]    led_out,
  output logic [PWM_BITS-1:0] brightness,
  output logic                cycle_done
);
  localparam int CW = $clog2(N_LED);
  localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [PWM_BITS-1:0] MAX_B      = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] ONE_B      = PWM_BITS'(1);
  localparam logic [PW-1:0]       PRESC_LAST = PW'(STEP_CYCLES - 1);
  localparam logic [PW-1:0]       ONE_P      = PW'(1);
  localparam logic [HW-1:0]       HOLD_LAST  = HW'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);
  localparam logic [HW-1:0]       ONE_H      = HW'(1);
  localparam logic [N_LED-1:0]    ONE_L      = N_LED'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PWM_BITS-1:0] bright_q, bright_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [CW-1:0]       chase_q, chase_d;
  logic [N_LED-1:0]    led_q, led_d;
  logic                done_q, done_d;
  logic [PWM_BITS-1:0] level_s;
  logic                active_s, tick_s, pwm_on_s;

  // Next set mask bit strictly above cur (wrapping); cur itself is the last candidate.
  function automatic logic [CW-1:0] next_chase(input logic [CW-1:0] cur, input logic [N_LED-1:0] m);
    logic [CW-1:0] res;
    logic          found;
    int            idx;
    res   = cur;
    found = 1'b0;
    for (int i = 1; i <= N_LED; i++) begin
      idx = (int'(cur) + i) % N_LED;
      if (!found && m[idx[CW-1:0]]) begin
        res   = idx[CW-1:0];
        found = 1'b1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

`ifdef LED_BREATH_GAMMA_EN
  logic [2*PWM_BITS-1:0] bright_sq_s;
  assign bright_sq_s = bright_q * bright_q;
  assign level_s     = bright_sq_s[2*PWM_BITS-1:PWM_BITS];
`else
  assign level_s = bright_q;
`endif

  assign active_s = (mode == 2'd1) || (mode == 2'd2);
  assign tick_s   = (presc_q == PRESC_LAST);
  assign pwm_on_s = (level_s > pwm_q);

  // Next-state logic: breath FSM, prescaler, chase pointer and LED drive.
  always_comb begin
    state_d  = state_q;
    bright_d = bright_q;
    presc_d  = presc_q;
    hold_d   = hold_q;
    chase_d  = chase_q;
    done_d   = 1'b0;
    pwm_d    = pwm_q + ONE_B;
    led_d    = '0;

    if (!active_s) begin
      state_d  = IDLE;
      bright_d = '0;
      presc_d  = '0;
      hold_d   = '0;
    end else if (pause) begin
      state_d = state_q;
    end else if (state_q == IDLE) begin
      state_d  = RISE;
      bright_d = '0;
      presc_d  = '0;
      hold_d   = '0;
    end else begin
      presc_d = tick_s ? '0 : presc_q + ONE_P;
      if (tick_s) begin
        case (state_q)
          RISE: begin
            bright_d = bright_q + ONE_B;
            if (bright_q == MAX_B - ONE_B) begin
              state_d = (HOLD_STEPS == 0) ? FALL : HOLD_HI;
            end else begin
              state_d = RISE;
            end
          end
          HOLD_HI: begin
            if (hold_q == HOLD_LAST) begin
              state_d = FALL;
              hold_d  = '0;
            end else begin
              hold_d = hold_q + ONE_H;
            end
          end
          FALL: begin
            bright_d = bright_q - ONE_B;
            if (bright_q == ONE_B) begin
              // Zero hold skips the trough and closes the cycle right here.
              state_d = (HOLD_STEPS == 0) ? RISE : HOLD_LO;
              done_d  = (HOLD_STEPS == 0);
            end else begin
              state_d = FALL;
            end
          end
          HOLD_LO: begin
            if (hold_q == HOLD_LAST) begin
              state_d = RISE;
              hold_d  = '0;
              done_d  = 1'b1;
            end else begin
              hold_d = hold_q + ONE_H;
            end
          end
          default: state_d = IDLE;
        endcase
      end else begin
        state_d = state_q;
      end
    end

    if (done_d && (mode == 2'd2)) begin
      chase_d = next_chase(chase_q, led_mask);
    end else begin
      chase_d = chase_q;
    end

    case (mode)
      2'd0:    led_d = '0;
      2'd1:    led_d = pwm_on_s ? led_mask : '0;
      2'd2:    led_d = pwm_on_s ? (led_mask & (ONE_L << chase_q)) : '0;
      2'd3:    led_d = led_mask;
      default: led_d = '0;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bright_q <= '0;
      pwm_q    <= '0;
      presc_q  <= '0;
      hold_q   <= '0;
      chase_q  <= '0;
      led_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bright_q <= bright_d;
      pwm_q    <= pwm_d;
      presc_q  <= presc_d;
      hold_q   <= hold_d;
      chase_q  <= chase_d;
      led_q    <= led_d;
      done_q   <= done_d;
    end
  end

  assign led_out    = led_q;
  assign brightness = bright_q;
  assign cycle_done = done_q;
endmodule
